// File: rtl/i2c_tgt_pkg.sv
// Shared types and bus constants for the I2C ADC target.
package i2c_tgt_pkg;
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_NACK, RDATA, RDATA_ACK, IGNORE
  } state_t;

  localparam logic I2C_READ_DIR  = 1'b1;
  localparam logic I2C_WRITE_DIR = 1'b0;
  localparam logic ACK           = 1'b0;
  localparam logic NACK          = 1'b1;
endpackage

// File: rtl/i2c_adc_target_if.sv
// ADC-side bundle of the I2C target: sample bus in, busy/strobe status out.
interface i2c_adc_target_if #(
  parameter int NUM_CH = 4
);
  logic [12*NUM_CH-1:0] sample;
  logic                 busy;
  logic                 rd_strobe;

  modport target (input sample, output busy, rd_strobe);
  modport host   (output sample, input busy, rd_strobe);
endinterface

// File: rtl/i2c_bus_sync.sv
// Two-flop synchronizers on SCL/SDA plus edge, START and STOP detection.
module i2c_bus_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic scl,
  input  logic sda,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);
  logic [1:0] scl_ff, sda_ff;
  logic       scl_d, sda_d, scl_s;

  // Reset to the idle-bus level so no spurious edge follows reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_ff <= 2'b11;
      sda_ff <= 2'b11;
      scl_d  <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_ff <= {scl_ff[0], scl};
      sda_ff <= {sda_ff[0], sda};
      scl_d  <= scl_ff[1];
      sda_d  <= sda_ff[1];
    end
  end

  assign scl_s    = scl_ff[1];
  assign sda_s    = sda_ff[1];
  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;
  assign start    = scl_s & scl_d & sda_d & ~sda_s;
  assign stop     = scl_s & scl_d & ~sda_d & sda_s;
endmodule

// File: rtl/i2c_adc_target.sv
// I2C target serving 12-bit ADC samples: pointer write, repeated START, sequential reads.
// Optional I2C_TGT_SNAPSHOT_EN: a low-byte read latches that channel's high nibble.
module i2c_adc_target
  import i2c_tgt_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h5E,
  parameter int         NUM_CH   = 4,
  parameter int         HOLD_CYC = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             scl,
  inout  wire              sda,
  i2c_adc_target_if.target adc
);
  state_t      state;
  logic [7:0]  sh, ptr, hcnt, ld_ptr, ld_byte;
  logic [6:0]  tx;
  logic [3:0]  bcnt, hi_nib;
  logic [11:0] live_w;
  logic        rw, mack, oe, oe_nxt, pend, busy_q, strobe_q, in_rng, do_load;
  logic        sda_s, scl_rise, scl_fall, start, stop;

  i2c_bus_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .scl      (scl),
    .sda      (sda),
    .sda_s    (sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  assign sda           = oe ? 1'b0 : 1'bz;
  assign adc.busy      = busy_q;
  assign adc.rd_strobe = strobe_q;

  // Byte source: the current ptr, or ptr+1 when loading after an initiator ack.
  assign ld_ptr  = (state == RDATA_ACK) ? ptr + 8'd1 : ptr;
  assign in_rng  = 9'(ld_ptr) < 9'(2*NUM_CH);
  assign do_load = scl_fall && ((state == ADDR_ACK && rw == I2C_READ_DIR) ||
                                (state == RDATA_ACK && mack == ACK));

  always_comb begin
    live_w = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (ld_ptr[7:1] == 7'(k)) live_w = adc.sample[12*k +: 12];
  end

`ifdef I2C_TGT_SNAPSHOT_EN
  // Only the high nibble needs holding: the low byte leaves at the moment it is latched.
  logic [3:0] snap_hi;
  logic [6:0] snap_ch;
  logic       snap_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_hi <= '0;
      snap_ch <= '0;
      snap_v  <= 1'b0;
    end else if (do_load && in_rng && !ld_ptr[0]) begin
      snap_hi <= live_w[11:8];
      snap_ch <= ld_ptr[7:1];
      snap_v  <= 1'b1;
    end
  end

  assign hi_nib = (snap_v && snap_ch == ld_ptr[7:1]) ? snap_hi : live_w[11:8];
`else
  assign hi_nib = live_w[11:8];
`endif

  always_comb begin
    if (!in_rng)        ld_byte = 8'h00;
    else if (!ld_ptr[0]) ld_byte = live_w[7:0];
    else                ld_byte = {4'h0, hi_nib};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sh       <= '0;
      tx       <= '0;
      ptr      <= '0;
      bcnt     <= '0;
      hcnt     <= '0;
      rw       <= I2C_WRITE_DIR;
      mack     <= NACK;
      oe       <= 1'b0;
      oe_nxt   <= 1'b0;
      pend     <= 1'b0;
      busy_q   <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      // SDA changes are queued at SCL fall and applied after the hold delay.
      if (pend) begin
        if (hcnt >= 8'(HOLD_CYC)) begin
          oe   <= oe_nxt;
          pend <= 1'b0;
        end else begin
          hcnt <= hcnt + 8'd1;
        end
      end

      if (stop) begin
        state  <= IDLE;
        oe     <= 1'b0;
        pend   <= 1'b0;
        busy_q <= 1'b0;
      end else if (start) begin
        state  <= ADDR;
        bcnt   <= '0;
        oe     <= 1'b0;
        pend   <= 1'b0;
        busy_q <= 1'b0;
      end else if (scl_rise) begin
        case (state)
          ADDR, PTR, WDATA: begin
            sh   <= {sh[6:0], sda_s};
            bcnt <= bcnt + 4'd1;
          end
          RDATA:     bcnt <= bcnt + 4'd1;
          RDATA_ACK: mack <= sda_s;
          default: ;
        endcase
      end else if (scl_fall) begin
        pend   <= 1'b1;
        hcnt   <= 8'd1;
        oe_nxt <= 1'b0;
        case (state)
          ADDR: if (bcnt == 4'd8) begin
            bcnt <= '0;
            if (sh[7:1] == DEV_ADDR) begin
              state  <= ADDR_ACK;
              rw     <= sh[0];
              busy_q <= 1'b1;
              oe_nxt <= 1'b1;
            end else begin
              state <= IGNORE;
            end
          end
          ADDR_ACK: state <= (rw == I2C_READ_DIR) ? RDATA : PTR;
          PTR: if (bcnt == 4'd8) begin
            bcnt   <= '0;
            ptr    <= sh;
            state  <= PTR_ACK;
            oe_nxt <= 1'b1;
          end
          PTR_ACK: state <= WDATA;
          WDATA: if (bcnt == 4'd8) begin
            bcnt  <= '0;
            state <= WDATA_NACK;
          end
          WDATA_NACK: begin
            state  <= IGNORE;
            busy_q <= 1'b0;
          end
          RDATA: begin
            if (bcnt == 4'd8) begin
              bcnt  <= '0;
              state <= RDATA_ACK;
            end else begin
              oe_nxt <= ~tx[6];
              tx     <= {tx[5:0], 1'b0};
            end
          end
          RDATA_ACK: begin
            ptr <= ptr + 8'd1;
            if (mack == ACK) begin
              state <= RDATA;
            end else begin
              state  <= IGNORE;
              busy_q <= 1'b0;
            end
          end
          default: ;
        endcase
        if (do_load) begin
          tx       <= ld_byte[6:0];
          oe_nxt   <= ~ld_byte[7];
          strobe_q <= 1'b1;
        end
      end
    end
  end
endmodule
